mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester (fetch / execute) arbiter in front of a single SRAM-like memory port.
// Holds at most one outstanding transaction and keeps the memory request stable from latched fields.
module mem_req_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int NPORT = 2;   // port 0 = inst, port 1 = data

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        grant_data;
    logic        accept;
    logic        complete;
    logic        live;

    logic [NPORT-1:0] port_addr_ok;
    logic [NPORT-1:0] port_data_ok;
    logic [31:0]      port_rdata [NPORT];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            wstrb_q <= 4'b0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        wstrb_d    = wstrb_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_data = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    grant_data = data_req && (DATA_FIRST || !inst_req);
                    owner_d    = grant_data;
                    // The fetch side is read-only, and a read never carries byte enables.
                    wr_d       = grant_data && data_wr;
                    wstrb_d    = (grant_data && data_wr) ? data_wstrb : 4'b0;
                    addr_d     = grant_data ? data_addr : inst_addr;
                    wdata_d    = grant_data ? data_wdata : 32'b0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_addr_ok) begin
                    accept = 1'b1;
                    if (mem_data_ok) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_data_ok) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset suppresses every output immediately, so an abandoned transaction never pulses.
    assign live      = !reset;
    assign mem_req   = live && (state_q == ST_REQ);
    assign mem_wr    = mem_req && wr_q;
    assign mem_wstrb = (mem_req && wr_q) ? wstrb_q : 4'b0;
    assign mem_addr  = mem_req ? addr_q : 32'b0;
    assign mem_wdata = mem_req ? wdata_q : 32'b0;
    assign busy      = live && (state_q != ST_IDLE);

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign port_addr_ok[gi] = live && accept && (owner_q == 1'(gi));
            assign port_data_ok[gi] = live && complete && (owner_q == 1'(gi));
            assign port_rdata[gi]   = port_data_ok[gi] ? mem_rdata : 32'b0;
        end
    endgenerate

    assign inst_addr_ok = port_addr_ok[0];
    assign inst_data_ok = port_data_ok[0];
    assign inst_rdata   = port_rdata[0];
    assign data_addr_ok = port_addr_ok[1];
    assign data_data_ok = port_data_ok[1];
    assign data_rdata   = port_rdata[1];

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Instance dut uses data-first priority, dut_b uses fetch-first priority.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        inst_req, data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        inst_req_b, data_req_b, data_wr_b;
    logic [3:0]  data_wstrb_b;
    logic [31:0] inst_addr_b, data_addr_b, data_wdata_b;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr, busy;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        inst_addr_ok_b, inst_data_ok_b, data_addr_ok_b, data_data_ok_b, mem_req_b, mem_wr_b, busy_b;
    logic [31:0] inst_rdata_b, data_rdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_wstrb_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_req_arbiter #(.DATA_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .inst_req(inst_req_b), .inst_addr(inst_addr_b), .inst_addr_ok(inst_addr_ok_b),
        .inst_data_ok(inst_data_ok_b), .inst_rdata(inst_rdata_b),
        .data_req(data_req_b), .data_wr(data_wr_b), .data_wstrb(data_wstrb_b), .data_addr(data_addr_b),
        .data_wdata(data_wdata_b), .data_addr_ok(data_addr_ok_b), .data_data_ok(data_data_ok_b),
        .data_rdata(data_rdata_b),
        .mem_req(mem_req_b), .mem_wr(mem_wr_b), .mem_wstrb(mem_wstrb_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle_inputs;
        inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        inst_req_b = 0; inst_addr_b = 0; data_req_b = 0; data_wr_b = 0; data_wstrb_b = 0; data_addr_b = 0; data_wdata_b = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic test_reset;
        logic [10:0] flags;
        logic [10:0] flags_b;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            inst_req = 1'($urandom); data_req = 1'($urandom); data_wr = 1'($urandom);
            data_wstrb = 4'($urandom); inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
            inst_req_b = 1'($urandom); data_req_b = 1'($urandom);
            mem_addr_ok = 1'($urandom); mem_data_ok = 1'($urandom); mem_rdata = $urandom;
            settle;
            flags   = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_req, mem_wr, busy, mem_wstrb};
            flags_b = {inst_addr_ok_b, inst_data_ok_b, data_addr_ok_b, data_data_ok_b, mem_req_b, mem_wr_b, busy_b, mem_wstrb_b};
            n_checks++; if (flags !== 11'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", flags); end
            n_checks++; if ((inst_rdata | data_rdata | mem_addr | mem_wdata) !== 32'b0) begin n_fail++; $display("FAIL reset_data got %h exp 0", inst_rdata | data_rdata | mem_addr | mem_wdata); end
            n_checks++; if (flags_b !== 11'b0) begin n_fail++; $display("FAIL reset_ctrl_b got %b exp 0", flags_b); end
        end
        tick;
        idle_inputs;
        reset = 0;
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h5a5a5a5a;
        settle;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
        n_checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) begin n_fail++; $display("FAIL idle_stray_ack got %b exp 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
        tick;
        idle_inputs;
        $display("txn reset: outputs held at zero, stray acks ignored while idle");
    endtask

    task automatic test_single_fetch;
        tick; inst_req = 1; inst_addr = 32'h1c000000; settle;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_memreq got %b exp 0", mem_req); end
        tick; inst_req = 0; settle;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_memreq got %b exp 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h1c000000) begin n_fail++; $display("FAIL fetch_addr got %h exp 1c000000", mem_addr); end
        n_checks++; if ({mem_wr, mem_wstrb} !== 5'b0) begin n_fail++; $display("FAIL fetch_readonly got %b exp 0", {mem_wr, mem_wstrb}); end
        n_checks++; if (inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_early_aok got %b exp 0", inst_addr_ok); end
        tick; mem_addr_ok = 1; settle;
        n_checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok} !== 3'b100) begin n_fail++; $display("FAIL fetch_aok got %b exp 100", {inst_addr_ok, data_addr_ok, inst_data_ok}); end
        tick; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h02800c0c; settle;
        n_checks++; if ({mem_req, inst_addr_ok, inst_data_ok, data_data_ok} !== 4'b0010) begin n_fail++; $display("FAIL fetch_dok got %b exp 0010", {mem_req, inst_addr_ok, inst_data_ok, data_data_ok}); end
        n_checks++; if (inst_rdata !== 32'h02800c0c) begin n_fail++; $display("FAIL fetch_rdata got %h exp 02800c0c", inst_rdata); end
        n_checks++; if (data_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_other_rdata got %h exp 0", data_rdata); end
        tick; mem_data_ok = 0; settle;
        n_checks++; if ({busy, inst_data_ok, inst_rdata} !== 34'b0) begin n_fail++; $display("FAIL fetch_after got %h exp 0", {busy, inst_data_ok, inst_rdata}); end
        tick; idle_inputs;
        $display("txn single_fetch: addr 1c000000 rdata 02800c0c");
    endtask

    task automatic test_priority;
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom; r2 = $urandom;
        tick;
        inst_req = 1; inst_addr = 32'h1c000004; data_req = 1; data_wr = 1; data_wstrb = 4'hf;
        data_addr = 32'h100; data_wdata = 32'h12345678;
        inst_req_b = 1; inst_addr_b = 32'h1c000004; data_req_b = 1; data_wr_b = 1; data_wstrb_b = 4'hf;
        data_addr_b = 32'h100; data_wdata_b = 32'h12345678;
        settle;
        tick; settle;
        n_checks++; if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {2'b11, 4'hf, 32'h100, 32'h12345678}) begin n_fail++; $display("FAIL prio_df1_first got %b/%b/%h/%h/%h exp 1/1/f/100/12345678", mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata); end
        n_checks++; if ({mem_req_b, mem_wr_b, mem_wstrb_b, mem_addr_b} !== {2'b10, 4'h0, 32'h1c000004}) begin n_fail++; $display("FAIL prio_df0_first got %b/%b/%h/%h exp 1/0/0/1c000004", mem_req_b, mem_wr_b, mem_wstrb_b, mem_addr_b); end
        mem_addr_ok = 1; settle;
        n_checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL prio_df1_aok got %b exp 10", {data_addr_ok, inst_addr_ok}); end
        n_checks++; if ({data_addr_ok_b, inst_addr_ok_b} !== 2'b01) begin n_fail++; $display("FAIL prio_df0_aok got %b exp 01", {data_addr_ok_b, inst_addr_ok_b}); end
        tick; mem_addr_ok = 0; data_req = 0; inst_req_b = 0; settle;
        n_checks++; if ({mem_req, busy, inst_addr_ok} !== 3'b010) begin n_fail++; $display("FAIL prio_wait got %b exp 010", {mem_req, busy, inst_addr_ok}); end
        mem_data_ok = 1; mem_rdata = r1; settle;
        n_checks++; if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, r1}) begin n_fail++; $display("FAIL prio_df1_dok got %b/%b/%h exp 1/0/%h", data_data_ok, inst_data_ok, data_rdata, r1); end
        n_checks++; if ({inst_data_ok_b, data_data_ok_b, inst_rdata_b} !== {2'b10, r1}) begin n_fail++; $display("FAIL prio_df0_dok got %b/%b/%h exp 1/0/%h", inst_data_ok_b, data_data_ok_b, inst_rdata_b, r1); end
        tick; mem_data_ok = 0; settle;
        n_checks++; if ({busy, busy_b} !== 2'b00) begin n_fail++; $display("FAIL prio_between got %b exp 00", {busy, busy_b}); end
        tick; settle;
        n_checks++; if ({mem_req, mem_wr, mem_addr} !== {2'b10, 32'h1c000004}) begin n_fail++; $display("FAIL prio_df1_second got %b/%b/%h exp 1/0/1c000004", mem_req, mem_wr, mem_addr); end
        n_checks++; if ({mem_req_b, mem_wr_b, mem_wstrb_b, mem_addr_b, mem_wdata_b} !== {2'b11, 4'hf, 32'h100, 32'h12345678}) begin n_fail++; $display("FAIL prio_df0_second got %b/%b/%h/%h/%h exp 1/1/f/100/12345678", mem_req_b, mem_wr_b, mem_wstrb_b, mem_addr_b, mem_wdata_b); end
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = r2; settle;
        n_checks++; if ({inst_addr_ok, inst_data_ok, inst_rdata} !== {2'b11, r2}) begin n_fail++; $display("FAIL prio_df1_done got %b/%b/%h exp 1/1/%h", inst_addr_ok, inst_data_ok, inst_rdata, r2); end
        n_checks++; if ({data_addr_ok_b, data_data_ok_b, data_rdata_b} !== {2'b11, r2}) begin n_fail++; $display("FAIL prio_df0_done got %b/%b/%h exp 1/1/%h", data_addr_ok_b, data_data_ok_b, data_rdata_b, r2); end
        tick; idle_inputs; settle;
        n_checks++; if ({busy, busy_b} !== 2'b00) begin n_fail++; $display("FAIL prio_end got %b exp 00", {busy, busy_b}); end
        $display("txn priority: data-first served store then fetch, fetch-first served fetch then store");
    endtask

    task automatic test_stall;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
        a = $urandom; w = $urandom; s = 4'($urandom_range(1, 15));
        tick; data_req = 1; data_wr = 1; data_addr = a; data_wdata = w; data_wstrb = s; settle;
        for (int i = 0; i < 5; i++) begin
            tick;
            data_req = 1'($urandom); data_wr = 1'($urandom); data_addr = $urandom;
            data_wdata = $urandom; data_wstrb = 4'($urandom); mem_data_ok = 1'($urandom);
            settle;
            n_checks++; if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {2'b11, s, a, w}) begin n_fail++; $display("FAIL stall_hold%0d got %b/%b/%h/%h/%h exp 1/1/%h/%h/%h", i, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, s, a, w); end
            n_checks++; if ({data_addr_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL stall_pulse%0d got %b exp 00", i, {data_addr_ok, data_data_ok}); end
        end
        tick; data_req = 0; mem_data_ok = 0; mem_addr_ok = 1; settle;
        n_checks++; if ({data_addr_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL stall_accept got %b exp 10", {data_addr_ok, data_data_ok}); end
        tick; mem_addr_ok = 0; mem_data_ok = 1; settle;
        n_checks++; if (data_data_ok !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b exp 1", data_data_ok); end
        tick; idle_inputs;
        $display("txn stall: store addr %h held through 5 stalled cycles", a);
    endtask

    task automatic test_same_cycle;
        tick; data_req = 1; data_wr = 0; data_wstrb = 4'ha; data_addr = 32'h300; settle;
        tick; data_req = 0; settle;
        n_checks++; if ({mem_wr, mem_wstrb} !== 5'b0) begin n_fail++; $display("FAIL load_wstrb got %b exp 0", {mem_wr, mem_wstrb}); end
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hdeadbeef; settle;
        n_checks++; if ({data_addr_ok, data_data_ok, data_rdata} !== {2'b11, 32'hdeadbeef}) begin n_fail++; $display("FAIL same_cycle got %b/%b/%h exp 1/1/deadbeef", data_addr_ok, data_data_ok, data_rdata); end
        n_checks++; if (inst_rdata !== 32'h0) begin n_fail++; $display("FAIL same_cycle_other got %h exp 0", inst_rdata); end
        tick; idle_inputs; settle;
        n_checks++; if ({busy, mem_req} !== 2'b00) begin n_fail++; $display("FAIL same_cycle_idle got %b exp 00", {busy, mem_req}); end
        $display("txn same_cycle: load rdata deadbeef");
    endtask

    task automatic test_reset_in_wait;
        tick; data_req = 1; data_addr = 32'h200; settle;
        tick; data_req = 0; mem_addr_ok = 1; settle;
        n_checks++; if (data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rstwait_aok got %b exp 1", data_addr_ok); end
        tick; mem_addr_ok = 0; settle;
        n_checks++; if ({busy, mem_req} !== 2'b10) begin n_fail++; $display("FAIL rstwait_wait got %b exp 10", {busy, mem_req}); end
        tick; reset = 1; mem_data_ok = 1; mem_rdata = 32'hcafef00d; settle;
        n_checks++; if ({busy, data_data_ok, data_rdata} !== 34'b0) begin n_fail++; $display("FAIL rstwait_in_reset got %h exp 0", {busy, data_data_ok, data_rdata}); end
        tick; reset = 0; settle;
        n_checks++; if ({busy, data_data_ok, inst_data_ok} !== 3'b0) begin n_fail++; $display("FAIL rstwait_after got %b exp 000", {busy, data_data_ok, inst_data_ok}); end
        tick; mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1c000010; settle;
        tick; inst_req = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h11223344; settle;
        n_checks++; if ({inst_addr_ok, inst_data_ok, inst_rdata} !== {2'b11, 32'h11223344}) begin n_fail++; $display("FAIL rstwait_next got %b/%b/%h exp 1/1/11223344", inst_addr_ok, inst_data_ok, inst_rdata); end
        tick; idle_inputs; settle;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_end got %b exp 0", busy); end
        $display("txn reset_in_wait: load abandoned, next fetch served");
    endtask

    // Transaction-level model: at most one transaction in flight, granted from pending requests when free.
    task automatic test_random;
        bit          pend [2];
        bit          drop [2];
        logic [31:0] p_addr [2];
        bit          p_wr;
        logic [3:0]  p_wstrb;
        logic [31:0] p_wdata;
        int          own;
        bit          acc;
        logic [31:0] e_addr, e_wdata;
        bit          e_wr;
        logic [3:0]  e_wstrb;
        bit          exp_aok [2];
        bit          exp_dok [2];
        int          ntx;
        own = -1; acc = 0; ntx = 0;
        e_addr = 0; e_wdata = 0; e_wr = 0; e_wstrb = 0;
        p_wr = 0; p_wstrb = 0; p_wdata = 0;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; drop[p] = 0; p_addr[p] = 0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick;
            for (int p = 0; p < 2; p++) begin
                if (drop[p]) pend[p] = 0;
                drop[p] = 0;
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    p_addr[p] = $urandom;
                    if (p == 1) begin p_wr = 1'($urandom); p_wstrb = 4'($urandom); p_wdata = $urandom; end
                end
            end
            inst_req = pend[0]; inst_addr = p_addr[0];
            data_req = pend[1]; data_addr = p_addr[1]; data_wr = p_wr; data_wstrb = p_wstrb; data_wdata = p_wdata;
            mem_addr_ok = ($urandom_range(0, 2) == 0);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            settle;

            exp_aok[0] = 0; exp_aok[1] = 0; exp_dok[0] = 0; exp_dok[1] = 0;
            if (own >= 0 && !acc && mem_addr_ok) begin
                exp_aok[own] = 1;
                exp_dok[own] = mem_data_ok;
            end else if (own >= 0 && acc) begin
                exp_dok[own] = mem_data_ok;
            end
            n_checks++; if (busy !== (own >= 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b exp %b", cyc, busy, own >= 0); end
            n_checks++; if (mem_req !== (own >= 0 && !acc)) begin n_fail++; $display("FAIL rnd_memreq cyc %0d got %b exp %b", cyc, mem_req, own >= 0 && !acc); end
            n_checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {exp_aok[0], exp_aok[1], exp_dok[0], exp_dok[1]}) begin n_fail++; $display("FAIL rnd_pulses cyc %0d got %b exp %b", cyc, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, {exp_aok[0], exp_aok[1], exp_dok[0], exp_dok[1]}); end
            n_checks++; if ({inst_rdata, data_rdata} !== {(exp_dok[0] ? mem_rdata : 32'h0), (exp_dok[1] ? mem_rdata : 32'h0)}) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h/%h", cyc, inst_rdata, data_rdata); end
            if (own >= 0 && !acc) begin
                n_checks++; if ({mem_wr, mem_wstrb, mem_addr} !== {e_wr, e_wstrb, e_addr}) begin n_fail++; $display("FAIL rnd_fields cyc %0d got %b/%h/%h exp %b/%h/%h", cyc, mem_wr, mem_wstrb, mem_addr, e_wr, e_wstrb, e_addr); end
                if (own == 1) begin
                    n_checks++; if (mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", cyc, mem_wdata, e_wdata); end
                end
            end

            if (own < 0) begin
                if (pend[0] || pend[1]) begin
                    own = (pend[1] && (!pend[0] || dut.DATA_FIRST)) ? 1 : 0;
                    acc = 0;
                    e_addr = p_addr[own];
                    e_wr = (own == 1) && p_wr;
                    e_wstrb = e_wr ? p_wstrb : 4'h0;
                    e_wdata = p_wdata;
                end
            end else if (!acc) begin
                if (mem_addr_ok) begin
                    drop[own] = 1;
                    if (mem_data_ok) begin
                        ntx++; $display("txn rnd %0d: port %s addr %h wr %b", ntx, own == 1 ? "data" : "inst", e_addr, e_wr);
                        own = -1;
                    end else begin
                        acc = 1;
                    end
                end
            end else if (mem_data_ok) begin
                ntx++; $display("txn rnd %0d: port %s addr %h wr %b", ntx, own == 1 ? "data" : "inst", e_addr, e_wr);
                own = -1;
            end
        end
        tick; idle_inputs;
    endtask

    initial begin
        idle_inputs;
        test_reset;
        test_single_fetch;
        test_priority;
        test_stall;
        test_same_cycle;
        test_reset_in_wait;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
